// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use stalls, multi-cycle mult/div freeze,
// advance-gated branch flushes and saturating stall/flush counters.
module hazard_stall_controller #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_Rt,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             MD_Start,
  input  logic             Branch_Taken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             ID_EX_Hold,
  output logic             EX_MEM_Bubble,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] MD_LOAD = CW'(MD_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic           load_use;
  logic           md_stall;
  logic           load_stall;

  assign load_use = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: MD_DONE is a one-cycle guard so a still-asserted MD_Start cannot retrigger
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (MD_Start) begin
          if (MD_LATENCY == 2) begin
            state_nxt = MD_DONE;
          end else begin
            state_nxt = MD_BUSY;
            cnt_nxt   = MD_LOAD;
          end
        end
      end
      MD_BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = MD_DONE;
        end
      end
      MD_DONE: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Outputs: mult/div freeze takes priority over the load-use bubble
  always_comb begin
    md_stall      = ((state == RUN) && MD_Start) || (state == MD_BUSY);
    load_stall    = (state == RUN) && !MD_Start && load_use;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    ID_EX_Hold    = 1'b0;
    EX_MEM_Bubble = 1'b0;
    MD_Busy       = 1'b0;
    if (md_stall) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Hold    = 1'b1;
      EX_MEM_Bubble = 1'b1;
      MD_Busy       = 1'b1;
    end else if (load_stall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  // A taken branch held in ID flushes only on a cycle the front end advances
  assign IF_ID_Flush = Branch_Taken & PC_Write;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (!PC_Write && (Stall_Count != CNT_MAX)) begin
        Stall_Count <= Stall_Count + CNT_W'(1);
      end
      if (IF_ID_Flush && (Flush_Count != CNT_MAX)) begin
        Flush_Count <= Flush_Count + CNT_W'(1);
      end
    end
  end

endmodule
